// File: rtl/ecrc_pkg.sv
// Shared ECRC constants, FSM state type and the final ECRC mapping used by
// both the TX generator and the RX checker.
package ecrc_pkg;

  localparam int          DW_WIDTH = 32;
  localparam logic [31:0] POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] SEED     = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Complement the CRC register, then bit-reverse each byte to form the ECRC DW.
  function automatic logic [31:0] ecrc_final(input logic [31:0] crc);
    logic [31:0] w_c;
    logic [31:0] w_m;
    w_c = ~crc;
    w_m = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        w_m[8*b+i] = w_c[8*b+7-i];
      end
    end
    return w_m;
  endfunction

endpackage

// File: rtl/ecrc_lfsr_dw.sv
// Combinational CRC-32 step over up to DW_NUM DWs of one beat, DW0 first,
// each DW fed MSB first. DWs at index >= i_len_dw leave the CRC untouched.
module ecrc_lfsr_dw
  import ecrc_pkg::*;
#(
  parameter  int DATA_WIDTH = 256,
  localparam int DW_NUM     = DATA_WIDTH / DW_WIDTH,
  localparam int CNT_W      = $clog2(DW_NUM) + 1
) (
  input  logic [31:0]           i_crc_in,
  input  logic [DATA_WIDTH-1:0] i_msg,
  input  logic [CNT_W-1:0]      i_len_dw,
  output logic [31:0]           o_crc_out
);

  always_comb begin
    logic [31:0] w_c;
    logic        w_fb;
    w_c  = i_crc_in;
    w_fb = 1'b0;
    for (int d = 0; d < DW_NUM; d++) begin
      if (d < int'(i_len_dw)) begin
        for (int k = 0; k < DW_WIDTH; k++) begin
          w_fb = w_c[31] ^ i_msg[DATA_WIDTH-1-DW_WIDTH*d-k];
          w_c  = {w_c[30:0], 1'b0} ^ (w_fb ? POLY : 32'h0);
        end
      end
    end
    o_crc_out = w_c;
  end

endmodule

// File: rtl/ecrc_rx_checker.sv
// RX ECRC checker: accumulates CRC-32 over each TLP and compares it against
// the trailing ECRC DW, reporting one cycle after the eop beat.
module ecrc_rx_checker
  import ecrc_pkg::*;
#(
  parameter  int DATA_WIDTH = 256,
  parameter  int DW_NUM     = DATA_WIDTH / DW_WIDTH,
  localparam int CNT_W      = $clog2(DW_NUM) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CNT_W-1:0]      i_last_dw_cnt,
  output logic                  o_chk_valid,
  output logic                  o_ecrc_err,
  output logic                  o_no_ecrc,
  output logic                  o_frame_err,
  output logic [31:0]           o_rx_ecrc,
  output logic [31:0]           o_calc_ecrc
);

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_crc;
  logic                  r_td;
  logic                  w_accept, w_check, w_frame_err;
  logic                  w_td;
  logic [DATA_WIDTH-1:0] w_msg;
  logic [31:0]           w_crc_in, w_crc_next, w_rx_dw, w_calc;
  logic [CNT_W-1:0]      w_cnt_m1, w_len;

  // A sop beat is always accepted; in ACCUM it also abandons the open TLP.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_check     = 1'b0;
    w_frame_err = 1'b0;
    if (i_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (i_sop) w_accept = 1'b1;
          else       w_frame_err = 1'b1;
        end
        ST_ACCUM: begin
          w_accept = 1'b1;
          if (i_sop) w_frame_err = 1'b1;
        end
        default: ;
      endcase
      if (w_accept) begin
        w_check     = i_eop;
        w_state_nxt = i_eop ? ST_IDLE : ST_ACCUM;
      end
    end
  end

  assign w_td     = i_sop ? i_data[DATA_WIDTH-17] : r_td;
  assign w_crc_in = i_sop ? SEED : r_crc;
  assign w_cnt_m1 = i_last_dw_cnt - CNT_W'(1);
  assign w_len    = !i_eop ? CNT_W'(DW_NUM) : (w_td ? w_cnt_m1 : i_last_dw_cnt);

  // Type[0] and EP are variant fields and enter the CRC as ones.
  always_comb begin
    w_msg = i_data;
    if (i_sop) begin
      w_msg[DATA_WIDTH-8]  = 1'b1;
      w_msg[DATA_WIDTH-18] = 1'b1;
    end
  end

  always_comb begin
    w_rx_dw = '0;
    for (int d = 0; d < DW_NUM; d++) begin
      if (d == int'(w_cnt_m1)) w_rx_dw = i_data[DATA_WIDTH-1-DW_WIDTH*d -: 32];
    end
  end

  ecrc_lfsr_dw #(.DATA_WIDTH(DATA_WIDTH)) u_lfsr (
    .i_crc_in  (w_crc_in),
    .i_msg     (w_msg),
    .i_len_dw  (w_len),
    .o_crc_out (w_crc_next)
  );

  assign w_calc = ecrc_final(w_crc_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_crc       <= SEED;
      r_td        <= 1'b0;
      o_chk_valid <= 1'b0;
      o_ecrc_err  <= 1'b0;
      o_no_ecrc   <= 1'b0;
      o_frame_err <= 1'b0;
      o_rx_ecrc   <= '0;
      o_calc_ecrc <= '0;
    end else begin
      r_state     <= w_state_nxt;
      o_chk_valid <= w_check;
      o_frame_err <= w_frame_err;
      o_ecrc_err  <= 1'b0;
      o_no_ecrc   <= 1'b0;
      if (w_accept) begin
        r_crc <= w_crc_next;
        r_td  <= w_td;
      end
      if (w_check) begin
        o_ecrc_err  <= w_td & (w_calc != w_rx_dw);
        o_no_ecrc   <= ~w_td;
        o_rx_ecrc   <= w_td ? w_rx_dw : 32'h0;
        o_calc_ecrc <= w_calc;
      end
    end
  end

endmodule

// File: tb/tb_ecrc_rx_checker.sv
// Bench for ecrc_rx_checker: scenario table, hand-written framing/reset
// sequences and random TLP traffic against a TLP-level reference model.
module tb_ecrc_rx_checker;

  localparam int DW  = 256;
  localparam int NDW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_sop, i_eop;
  logic [DW-1:0] i_data;
  logic [3:0]    i_last_dw_cnt;
  logic          o_chk_valid, o_ecrc_err, o_no_ecrc, o_frame_err;
  logic [31:0]   o_rx_ecrc, o_calc_ecrc;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_dws[$];
  bit          m_in_tlp = 1'b0;

  ecrc_rx_checker #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_sop         (i_sop),
    .i_eop         (i_eop),
    .i_data        (i_data),
    .i_last_dw_cnt (i_last_dw_cnt),
    .o_chk_valid   (o_chk_valid),
    .o_ecrc_err    (o_ecrc_err),
    .o_no_ecrc     (o_no_ecrc),
    .o_frame_err   (o_frame_err),
    .o_rx_ecrc     (o_rx_ecrc),
    .o_calc_ecrc   (o_calc_ecrc)
  );

  always #5 clk = ~clk;

  // Reference: CRC-32 long division of the DW stream, variant bits of DW0 set.
  function automatic logic [31:0] ref_crc(input logic [31:0] q[$], input int n);
    logic [31:0] crc;
    logic [31:0] w;
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      w = q[i];
      if (i == 0) w = w | 32'h0100_4000;
      for (int k = 31; k >= 0; k--) begin
        if (crc[31] ^ w[k]) crc = (crc << 1) ^ 32'h04C1_1DB7;
        else                crc = crc << 1;
      end
    end
    return crc;
  endfunction

  function automatic logic [31:0] ref_final(input logic [31:0] crc);
    logic [31:0] c;
    logic [31:0] m;
    c = ~crc;
    for (int i = 0; i < 32; i++) m[i] = c[(i/8)*8 + 7 - (i%8)];
    return m;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle, update the model, then compare the registered outputs.
  task automatic beat(input bit v, input bit s, input bit e, input logic [DW-1:0] d, input int cnt);
    bit          xc, xf, xe, xn, td;
    logic [31:0] xr, xk;
    int          n;
    i_valid = v; i_sop = s; i_eop = e; i_data = d; i_last_dw_cnt = 4'(cnt);
    xc = 0; xf = 0; xe = 0; xn = 0; xr = '0; xk = '0;
    if (v) begin
      if (s) begin
        xf = m_in_tlp;
        m_dws.delete();
        m_in_tlp = 1'b1;
      end else if (!m_in_tlp) begin
        xf = 1'b1;
      end
      if (m_in_tlp) begin
        n = e ? cnt : NDW;
        for (int i = 0; i < n; i++) m_dws.push_back(d[DW-1-32*i -: 32]);
        if (e) begin
          xc = 1'b1;
          m_in_tlp = 1'b0;
          td = m_dws[0][15];
          if (td) begin
            xr = m_dws[m_dws.size()-1];
            xk = ref_final(ref_crc(m_dws, m_dws.size()-1));
            xe = (xr != xk);
          end else begin
            xk = ref_final(ref_crc(m_dws, m_dws.size()));
            xn = 1'b1;
          end
        end
      end
    end
    @(posedge clk); #1;
    check1("chk_valid", o_chk_valid, xc);
    check1("frame_err", o_frame_err, xf);
    if (xc) begin
      check1("ecrc_err", o_ecrc_err, xe);
      check1("no_ecrc", o_no_ecrc, xn);
      check32("rx_ecrc", o_rx_ecrc, xr);
      check32("calc_ecrc", o_calc_ecrc, xk);
    end
  endtask

  task automatic idle();
    beat(1'b0, 1'($urandom), 1'($urandom), {NDW{$urandom}}, $urandom_range(1, NDW));
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [31:0] t[$], input int b);
    logic [DW-1:0] d;
    for (int i = 0; i < NDW; i++)
      d[DW-1-32*i -: 32] = (8*b + i < t.size()) ? t[8*b+i] : $urandom;
    return d;
  endfunction

  function automatic int beat_cnt(input logic [31:0] t[$], input int b);
    int rem;
    rem = t.size() - 8*b;
    return (rem > NDW) ? NDW : rem;
  endfunction

  task automatic make_tlp(input bit h4, input int np, input bit td,
                          output logic [31:0] t[$], output logic [31:0] ecrc);
    t.delete();
    t.push_back({(h4 ? 3'b011 : 3'b010), 5'b00000, 8'h00, td, 1'b0, 4'h0, 10'(np)});
    for (int i = 0; i < (h4 ? 3 : 2); i++) t.push_back($urandom);
    for (int i = 0; i < np; i++) t.push_back($urandom);
    ecrc = ref_final(ref_crc(t, t.size()));
    if (td) t.push_back(ecrc);
  endtask

  task automatic send_tlp(input logic [31:0] t[$], input int gap_beat, input int gap_len);
    int nb;
    nb = (t.size() + NDW - 1) / NDW;
    for (int b = 0; b < nb; b++) begin
      if (b == nb - 1) beat(1'b1, b == 0, 1'b1, beat_data(t, b), beat_cnt(t, b));
      else             beat(1'b1, b == 0, 1'b0, beat_data(t, b), $urandom_range(1, NDW));
      if (b == gap_beat && b != nb - 1) repeat (gap_len) idle();
    end
  endtask

  typedef struct {
    string name;
    bit    h4;
    int    np;
    bit    td;
    bit    flip;
    bit    variant;
    int    gap_beat;
    int    gap_len;
    bit    exp_err;
    bit    exp_no;
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset_check();
    rst = 1'b1; i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    @(posedge clk); #1;
    m_in_tlp = 1'b0;
    check1("rst_chk_valid", o_chk_valid, 1'b0);
    check1("rst_ecrc_err", o_ecrc_err, 1'b0);
    check1("rst_no_ecrc", o_no_ecrc, 1'b0);
    check1("rst_frame_err", o_frame_err, 1'b0);
    check32("rst_rx_ecrc", o_rx_ecrc, 32'h0);
    check32("rst_calc_ecrc", o_calc_ecrc, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] t[$];
    logic [31:0] t2[$];
    logic [31:0] good, good2;

    vecs[0] = '{"mwr_1beat",     1'b0,  1, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0};
    vecs[1] = '{"mwr_flip",      1'b0,  1, 1'b1, 1'b1, 1'b0, -1, 0, 1'b1, 1'b0};
    vecs[2] = '{"mwr_variant",   1'b0,  1, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0};
    vecs[3] = '{"multi_gap",     1'b1, 16, 1'b1, 1'b0, 1'b0,  0, 2, 1'b0, 1'b0};
    vecs[4] = '{"b2b_1beat",     1'b0,  1, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0};
    vecs[5] = '{"td0_3beat",     1'b1, 18, 1'b0, 1'b0, 1'b0,  1, 1, 1'b0, 1'b1};

    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_data = '0; i_last_dw_cnt = 4'd1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset_check();
    idle();

    foreach (vecs[v]) begin
      make_tlp(vecs[v].h4, vecs[v].np, vecs[v].td, t, good);
      if (vecs[v].flip) t[t.size()-1] = t[t.size()-1] ^ 32'h1;
      if (vecs[v].variant) t[0] = (t[0] | 32'h0000_4000) ^ 32'h0100_0000;
      send_tlp(t, vecs[v].gap_beat, vecs[v].gap_len);
      check1({vecs[v].name, "_valid"}, o_chk_valid, 1'b1);
      check1({vecs[v].name, "_err"}, o_ecrc_err, vecs[v].exp_err);
      check1({vecs[v].name, "_no"}, o_no_ecrc, vecs[v].exp_no);
      check32({vecs[v].name, "_calc"}, o_calc_ecrc, good);
      if (vecs[v].td) check32({vecs[v].name, "_rx"}, o_rx_ecrc, vecs[v].flip ? (good ^ 32'h1) : good);
    end
    idle();

    // sop while a TLP is open: frame error, and the new TLP still checks.
    make_tlp(1'b1, 16, 1'b1, t, good);
    make_tlp(1'b0, 1, 1'b1, t2, good2);
    beat(1'b1, 1'b1, 1'b0, beat_data(t, 0), NDW);
    beat(1'b1, 1'b1, 1'b1, beat_data(t2, 0), beat_cnt(t2, 0));
    check1("sop_in_accum_ferr", o_frame_err, 1'b1);
    check1("sop_in_accum_valid", o_chk_valid, 1'b1);
    check1("sop_in_accum_err", o_ecrc_err, 1'b0);
    check32("sop_in_accum_calc", o_calc_ecrc, good2);
    idle();

    // Reset mid-TLP: leftover beats are orphans.
    beat(1'b1, 1'b1, 1'b0, beat_data(t, 0), NDW);
    do_reset_check();
    beat(1'b1, 1'b0, 1'b0, beat_data(t, 1), NDW);
    check1("post_rst_ferr1", o_frame_err, 1'b1);
    beat(1'b1, 1'b0, 1'b1, beat_data(t, 2), beat_cnt(t, 2));
    check1("post_rst_ferr2", o_frame_err, 1'b1);
    check1("post_rst_no_chk", o_chk_valid, 1'b0);
    idle();

    // Random traffic against the model.
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 9) == 0) begin
        beat(1'b1, 1'b0, 1'($urandom), {NDW{$urandom}}, $urandom_range(1, NDW));
      end else begin
        make_tlp(1'($urandom), $urandom_range(0, 24), 1'($urandom), t, good);
        if ($urandom_range(0, 3) == 0) t[t.size()-1] = t[t.size()-1] ^ (32'h1 << $urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) t[0] = t[0] ^ 32'h0100_4000;
        send_tlp(t, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      if ($urandom_range(0, 2) == 0) idle();
    end

    i_valid = 1'b0;
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
